rotation_kick_sequencer: RTL and testbench

ROTATION_KICK_SEQUENCER -- requirements
Module: rotation_kick_sequencer

---
 rtl/rotation_kick_sequencer.sv | 200 ++++++++++++++++++++
 tb/tb_rotation_kick_sequencer.sv | 268 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/rotation_kick_sequencer.sv
// rotation_kick_sequencer: walks the SRS wall-kick tests for one rotation,
// querying an external collision checker for each candidate pose until one
// is free or the tests run out.
// Optional build macro KICK_TIMEOUT_EN adds a 'timeout' output and a 4-bit
// WAIT watchdog that gives up after 16 cycles without a checker response.
module rotation_kick_sequencer #(
  parameter int TEST_POSITIONS = 5,
  parameter int COORD_W        = 6
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic                      rot_req,
  input  logic                      rot_dir,
  input  logic                      is_i_piece,
  input  logic [1:0]                cur_orient,
  input  logic signed [COORD_W-1:0] cur_x,
  input  logic signed [COORD_W-1:0] cur_y,
  output logic                      q_valid,
  input  logic                      q_ready,
  output logic [1:0]                q_orient,
  output logic signed [COORD_W-1:0] q_x,
  output logic signed [COORD_W-1:0] q_y,
  input  logic                      r_valid,
  input  logic                      r_collide,
  output logic                      busy,
  output logic                      done,
  output logic                      success,
  output logic [1:0]                new_orient,
  output logic signed [COORD_W-1:0] new_x,
  output logic signed [COORD_W-1:0] new_y,
`ifdef KICK_TIMEOUT_EN
  output logic                      timeout,
`endif
  output logic [2:0]                kick_idx
);

  localparam logic [1:0] IDLE  = 2'd0;
  localparam logic [1:0] ISSUE = 2'd1;
  localparam logic [1:0] WAIT  = 2'd2;
  localparam logic [1:0] DONE  = 2'd3;

  // Kick rows, five {dx,dy} nibble pairs (test 0 in the top byte), y up.
  // Every SRS transition is one of these rows or its negation.
  localparam logic [39:0] ROW_A = 40'h00_F0_F1_0E_FE; // JLSTZ 0->R, 2->R
  localparam logic [39:0] ROW_C = 40'h00_10_11_0E_1E; // JLSTZ 0->L, 2->L
  localparam logic [39:0] ROW_P = 40'h00_E0_10_EF_12; // I 0->R, L->2
  localparam logic [39:0] ROW_Q = 40'h00_F0_20_F2_2F; // I 0->L, R->2

  localparam logic [2:0] LAST_K = 3'(TEST_POSITIONS - 1);

  logic [1:0]                state;
  logic [2:0]                k;
  logic [1:0]                lat_orient;
  logic signed [COORD_W-1:0] lat_x, lat_y;
  logic                      lat_dir, lat_i;
`ifdef KICK_TIMEOUT_EN
  logic [3:0]                wcnt;
`endif

  logic [1:0]                tgt_orient;
  logic [39:0]               row;
  logic                      neg;
  logic [7:0]                ent;
  logic signed [3:0]         dx4, dy4;
  logic signed [COORD_W-1:0] pose_x, pose_y;

  assign tgt_orient = lat_dir ? lat_orient - 2'd1 : lat_orient + 2'd1;

  // Select the kick row for the latched (from, direction) and extract test k.
  always_comb begin
    row = '0;
    neg = 1'b0;
    case ({lat_i, lat_orient, lat_dir})
      4'b0_00_0: row = ROW_A;
      4'b0_00_1: row = ROW_C;
      4'b0_01_0, 4'b0_01_1: begin row = ROW_A; neg = 1'b1; end
      4'b0_10_0: row = ROW_C;
      4'b0_10_1: row = ROW_A;
      4'b0_11_0, 4'b0_11_1: begin row = ROW_C; neg = 1'b1; end
      4'b1_00_0: row = ROW_P;
      4'b1_00_1: row = ROW_Q;
      4'b1_01_0: row = ROW_Q;
      4'b1_01_1: begin row = ROW_P; neg = 1'b1; end
      4'b1_10_0: begin row = ROW_P; neg = 1'b1; end
      4'b1_10_1: begin row = ROW_Q; neg = 1'b1; end
      4'b1_11_0: begin row = ROW_Q; neg = 1'b1; end
      4'b1_11_1: row = ROW_P;
      default:   row = '0;
    endcase
    // Tests past the fifth (larger TEST_POSITIONS) retry the unkicked pose.
    case (k)
      3'd0:    ent = row[39:32];
      3'd1:    ent = row[31:24];
      3'd2:    ent = row[23:16];
      3'd3:    ent = row[15:8];
      3'd4:    ent = row[7:0];
      default: ent = 8'h00;
    endcase
    dx4 = ent[7:4];
    dy4 = ent[3:0];
    if (neg) begin
      dx4 = -dx4;
      dy4 = -dy4;
    end
    // Two's complement wrap at COORD_W is intended; no saturation.
    pose_x = lat_x + COORD_W'(dx4);
    pose_y = lat_y + COORD_W'(dy4);
  end

  assign q_valid  = (state == ISSUE);
  assign busy     = (state != IDLE);
  assign done     = (state == DONE);
  // Pose is only driven while a query is offered so the outputs idle at 0.
  assign q_orient = q_valid ? tgt_orient : 2'd0;
  assign q_x      = q_valid ? pose_x : '0;
  assign q_y      = q_valid ? pose_y : '0;

  // Sequencer FSM plus the latched request and the held result registers.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state      <= IDLE;
      k          <= '0;
      lat_orient <= '0;
      lat_x      <= '0;
      lat_y      <= '0;
      lat_dir    <= 1'b0;
      lat_i      <= 1'b0;
      success    <= 1'b0;
      new_orient <= '0;
      new_x      <= '0;
      new_y      <= '0;
      kick_idx   <= '0;
`ifdef KICK_TIMEOUT_EN
      wcnt       <= '0;
      timeout    <= 1'b0;
`endif
    end else begin
      case (state)
        IDLE: if (rot_req) begin
          lat_orient <= cur_orient;
          lat_x      <= cur_x;
          lat_y      <= cur_y;
          lat_dir    <= rot_dir;
          lat_i      <= is_i_piece;
          k          <= '0;
          state      <= ISSUE;
        end
        ISSUE: if (q_ready) begin
          state <= WAIT;
`ifdef KICK_TIMEOUT_EN
          wcnt  <= '0;
`endif
        end
        WAIT: begin
          if (r_valid) begin
            if (!r_collide) begin
              state      <= DONE;
              success    <= 1'b1;
              new_orient <= tgt_orient;
              new_x      <= pose_x;
              new_y      <= pose_y;
              kick_idx   <= k;
`ifdef KICK_TIMEOUT_EN
              timeout    <= 1'b0;
`endif
            end else if (k == LAST_K) begin
              state      <= DONE;
              success    <= 1'b0;
              new_orient <= lat_orient;
              new_x      <= lat_x;
              new_y      <= lat_y;
              kick_idx   <= k;
`ifdef KICK_TIMEOUT_EN
              timeout    <= 1'b0;
`endif
            end else begin
              k     <= k + 3'd1;
              state <= ISSUE;
            end
          end
`ifdef KICK_TIMEOUT_EN
          else if (wcnt == 4'd15) begin
            state      <= DONE;
            success    <= 1'b0;
            timeout    <= 1'b1;
            new_orient <= lat_orient;
            new_x      <= lat_x;
            new_y      <= lat_y;
            kick_idx   <= k;
          end else begin
            wcnt <= wcnt + 4'd1;
          end
`endif
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_rotation_kick_sequencer.sv
// Randomized bench for rotation_kick_sequencer. Kick offsets come from the
// SRS per-orientation offset data (kick = offset[from]-offset[to], re-centred
// on test 0) rather than from the kick tables themselves.
module tb_rotation_kick_sequencer;
  localparam int TP = 5;
  localparam int CW = 6;

  logic          clk = 1'b0;
  logic          rst;
  logic          rot_req, rot_dir, is_i_piece;
  logic [1:0]    cur_orient;
  logic [CW-1:0] cur_x, cur_y;
  logic          q_valid, q_ready;
  logic [1:0]    q_orient;
  logic [CW-1:0] q_x, q_y;
  logic          r_valid, r_collide;
  logic          busy, done, success;
  logic [1:0]    new_orient;
  logic [CW-1:0] new_x, new_y;
  logic [2:0]    kick_idx;
`ifdef KICK_TIMEOUT_EN
  logic          timeout;
`endif

  rotation_kick_sequencer #(.TEST_POSITIONS(TP), .COORD_W(CW)) dut (
    .clk(clk), .rst(rst), .rot_req(rot_req), .rot_dir(rot_dir),
    .is_i_piece(is_i_piece), .cur_orient(cur_orient), .cur_x(cur_x), .cur_y(cur_y),
    .q_valid(q_valid), .q_ready(q_ready), .q_orient(q_orient), .q_x(q_x), .q_y(q_y),
    .r_valid(r_valid), .r_collide(r_collide), .busy(busy), .done(done),
    .success(success), .new_orient(new_orient), .new_x(new_x), .new_y(new_y),
`ifdef KICK_TIMEOUT_EN
    .timeout(timeout),
`endif
    .kick_idx(kick_idx)
  );

  always #5 clk = ~clk;

  int n_vec = 0;
  int n_bad = 0;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // SRS offset data per orientation (0,R,2,L), y up.
  function automatic int off_x(bit i, int o, int k);
    int t[5];
    t = '{0, 0, 0, 0, 0};
    if (i) begin
      case (o)
        0: t = '{0, -1, 2, -1, 2};
        1: t = '{-1, 0, 0, 0, 0};
        2: t = '{-1, 1, -2, 1, -2};
        default: t = '{0, 0, 0, 0, 0};
      endcase
    end else begin
      case (o)
        1: t = '{0, 1, 1, 0, 1};
        3: t = '{0, -1, -1, 0, -1};
        default: t = '{0, 0, 0, 0, 0};
      endcase
    end
    return t[k];
  endfunction

  function automatic int off_y(bit i, int o, int k);
    int t[5];
    t = '{0, 0, 0, 0, 0};
    if (i) begin
      case (o)
        1: t = '{0, 0, 0, 1, -2};
        2: t = '{1, 1, 1, 0, 0};
        3: t = '{1, 1, 1, -1, 2};
        default: t = '{0, 0, 0, 0, 0};
      endcase
    end else begin
      case (o)
        1, 3: t = '{0, 0, -1, 2, 2};
        default: t = '{0, 0, 0, 0, 0};
      endcase
    end
    return t[k];
  endfunction

  function automatic int kick_dx(bit i, int f, int t, int k);
    if (k >= 5) return 0;
    return (off_x(i, f, k) - off_x(i, t, k)) - (off_x(i, f, 0) - off_x(i, t, 0));
  endfunction

  function automatic int kick_dy(bit i, int f, int t, int k);
    if (k >= 5) return 0;
    return (off_y(i, f, k) - off_y(i, t, k)) - (off_y(i, f, 0) - off_y(i, t, 0));
  endfunction

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  // One full rotation against a scripted checker; mask[k]=1 means test k collides.
  task automatic run_rot(input bit i, input logic [1:0] o, input bit dir,
                         input logic [CW-1:0] x, input logic [CW-1:0] y,
                         input logic [TP-1:0] mask, input int smin, input int smax,
                         input int lmin, input int lmax);
    logic [1:0]    to;
    logic [CW-1:0] ex, ey;
    logic [1:0]    eo;
    logic [CW-1:0] fx, fy;
    int            d, k, stall, lat;
    to = dir ? o - 2'd1 : o + 2'd1;
    rot_req = 1'b1; is_i_piece = i; cur_orient = o; rot_dir = dir; cur_x = x; cur_y = y;
    tick;
    rot_req = 1'b0;
    cur_x = CW'($urandom); cur_y = CW'($urandom); cur_orient = 2'($urandom);
    rot_dir = 1'($urandom); is_i_piece = 1'($urandom);
    ex = '0; ey = '0;
    for (k = 0; k < TP; k++) begin
      d  = kick_dx(i, int'(o), int'(to), k);
      ex = x + d[CW-1:0];
      d  = kick_dy(i, int'(o), int'(to), k);
      ey = y + d[CW-1:0];
      stall = $urandom_range(smax, smin);
      for (int s = 0; s < stall; s++) begin
        q_ready = 1'b0; r_valid = 1'($urandom); r_collide = 1'b0;
        rot_req = 1'($urandom); cur_x = CW'($urandom);
        @(negedge clk);
        chk("stall_qvalid", {31'd0, q_valid}, 1);
        chk("stall_pose", {18'd0, q_orient, q_x, q_y}, {18'd0, to, ex, ey});
        tick;
      end
      q_ready = 1'b1; r_valid = 1'b0; rot_req = 1'b0;
      @(negedge clk);
      chk("q_valid", {31'd0, q_valid}, 1);
      chk("q_pose", {18'd0, q_orient, q_x, q_y}, {18'd0, to, ex, ey});
      tick;
      q_ready = 1'b0;
      lat = $urandom_range(lmax, lmin);
      for (int w = 0; w < lat; w++) begin
        rot_req = 1'($urandom);
        @(negedge clk);
        chk("wait_qvalid", {31'd0, q_valid}, 0);
        chk("wait_done", {31'd0, done}, 0);
        tick;
      end
      rot_req = 1'b0; r_valid = 1'b1; r_collide = mask[k];
      tick;
      r_valid = 1'b0; r_collide = 1'b0;
      if (!mask[k] || k == TP - 1) break;
    end
    if (!mask[k]) begin eo = to; fx = ex; fy = ey; end
    else begin eo = o; fx = x; fy = y; end
    @(negedge clk);
    chk("done_pulse", {31'd0, done}, 1);
    chk("success", {31'd0, success}, {31'd0, ~mask[k]});
    chk("new_pose", {18'd0, new_orient, new_x, new_y}, {18'd0, eo, fx, fy});
    chk("kick_idx", {29'd0, kick_idx}, k);
`ifdef KICK_TIMEOUT_EN
    chk("timeout_clear", {31'd0, timeout}, 0);
`endif
    tick;
    @(negedge clk);
    chk("done_one_cycle", {31'd0, done}, 0);
    chk("idle_after", {31'd0, busy}, 0);
    chk("result_hold", {18'd0, new_orient, new_x, new_y}, {18'd0, eo, fx, fy});
    tick;
  endtask

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    rst = 1'b1; rot_req = 1'b0; rot_dir = 1'b0; is_i_piece = 1'b0; cur_orient = '0;
    cur_x = '0; cur_y = '0; q_ready = 1'b0; r_valid = 1'b0; r_collide = 1'b0;
    #1;
    chk("reset_outputs", {12'd0, q_valid, busy, done, success, new_orient, new_x, new_y, kick_idx},
        32'd0);
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;
    tick;

    // Non-I 0->R, first test free
    run_rot(1'b0, 2'd0, 1'b0, 6'd4, 6'd10, 5'b00000, 0, 0, 0, 0);
    chk("d035_pose", {18'd0, new_orient, new_x, new_y}, {18'd0, 2'd1, 6'd4, 6'd10});
    chk("d035_kick", {29'd0, kick_idx}, 0);
    // Non-I 0->R, tests 0-2 collide
    run_rot(1'b0, 2'd0, 1'b0, 6'd4, 6'd10, 5'b00111, 0, 1, 0, 2);
    chk("d036_pose", {18'd0, new_orient, new_x, new_y}, {18'd0, 2'd1, 6'd4, 6'd8});
    chk("d036_kick", {29'd0, kick_idx}, 3);
    // I piece R, cw, everything collides
    run_rot(1'b1, 2'd1, 1'b0, 6'd5, 6'd7, 5'b11111, 0, 2, 0, 2);
    chk("d037_fail", {28'd0, success, kick_idx}, {28'd0, 1'b0, 3'd4});
    chk("d037_pose", {18'd0, new_orient, new_x, new_y}, {18'd0, 2'd1, 6'd5, 6'd7});
    // I piece L, cw, test 1 free, q_ready stalls 3 cycles per query
    run_rot(1'b1, 2'd3, 1'b0, 6'd3, 6'd2, 5'b00001, 3, 3, 1, 1);
    chk("d038_pose", {18'd0, new_orient, new_x, new_y}, {18'd0, 2'd0, 6'd4, 6'd2});
    // Coordinate wrap: 31 + 2 wraps to -31 (I 0->L, test 2 dx=+2)
    run_rot(1'b1, 2'd0, 1'b1, 6'd31, 6'd0, 5'b00011, 0, 0, 0, 0);
    chk("wrap_x", {26'd0, new_x}, {26'd0, 6'h21});

    for (int n = 0; n < 150; n++) begin
      for (int g = 0; g < int'($urandom_range(2, 0)); g++) begin
        r_valid = 1'($urandom); r_collide = 1'($urandom);
        @(negedge clk);
        chk("idle_busy", {31'd0, busy}, 0);
        tick;
      end
      r_valid = 1'b0; r_collide = 1'b0;
      run_rot(1'($urandom), 2'($urandom), 1'($urandom), CW'($urandom), CW'($urandom),
              TP'($urandom), 0, 3, 0, 4);
    end

    // Reset while waiting for a response abandons the rotation
    rot_req = 1'b1; cur_orient = 2'd2; cur_x = 6'd9; cur_y = 6'd9; rot_dir = 1'b0;
    is_i_piece = 1'b0;
    tick;
    rot_req = 1'b0; q_ready = 1'b1;
    tick;
    q_ready = 1'b0;
    @(negedge clk);
    chk("pre_rst_busy", {31'd0, busy}, 1);
    #1 rst = 1'b1;
    #1;
    chk("rst_async", {12'd0, q_valid, busy, done, success, new_orient, new_x, new_y, kick_idx},
        32'd0);
`ifdef KICK_TIMEOUT_EN
    chk("rst_timeout", {31'd0, timeout}, 0);
`endif
    tick;
    rst = 1'b0;
    r_valid = 1'b1; r_collide = 1'b0;
    tick;
    r_valid = 1'b0;
    for (int w = 0; w < 3; w++) begin
      @(negedge clk);
      chk("rst_no_done", {30'd0, done, busy}, 0);
      tick;
    end

`ifdef KICK_TIMEOUT_EN
    // Checker never answers: give up after 16 cycles in WAIT
    rot_req = 1'b1; cur_orient = 2'd0; cur_x = 6'd4; cur_y = 6'd10; rot_dir = 1'b0;
    tick;
    rot_req = 1'b0; q_ready = 1'b1;
    tick;
    q_ready = 1'b0;
    for (int w = 0; w < 16; w++) begin
      @(negedge clk);
      chk("to_wait", {31'd0, done}, 0);
      tick;
    end
    @(negedge clk);
    chk("to_done", {29'd0, done, timeout, success}, {29'd0, 3'b110});
    chk("to_pose", {18'd0, new_orient, new_x, new_y}, {18'd0, 2'd0, 6'd4, 6'd10});
    tick;
`endif

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end
endmodule
